// File: rtl/cheri_id_ex_pipe_pkg.sv
// Shared types for the CHERI ID->EX handoff: decoded payload layout and operator encoding.
package cheri_id_ex_pipe_pkg;

    localparam int OPDW       = 8;
    localparam int MAX_PHASES = 4;

    typedef enum logic [2:0] {
        OP_ALU,
        OP_CSET_BOUNDS,
        OP_CRRL,
        OP_CRAM,
        OP_CLC,
        OP_CSC,
        OP_CMOVE,
        OP_CGET
    } cheri_op_e;

    typedef struct packed {
        logic [OPDW-1:0] operator;
        logic [11:0]     imm12;
        logic [19:0]     imm20;
        logic [20:0]     imm21;
        logic [4:0]      cs2;
        logic            rf_we;
        logic            multicycle;
    } cheri_dec_pl_t;

    localparam int PLW = $bits(cheri_dec_pl_t);

    function automatic logic [OPDW-1:0] opOneHot(input cheri_op_e op);
        return OPDW'(1) << int'(op);
    endfunction

endpackage

// File: rtl/cheri_id_ex_pipe_skid.sv
// Generic one-entry skid holding register; a write wins over a simultaneous pop.
module cheri_skid_reg #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         wr_i,
    input  logic [W-1:0] data_i,
    input  logic         rd_i,
    output logic         valid_o,
    output logic         ready_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (wr_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (rd_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign ready_o = ~valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/cheri_id_ex_pipe.sv
// Registered ID->EX handoff with one-entry skid and multicycle phase sequencing.
// Optional CHERI_ID_EX_PERF_EN adds saturating stall and multicycle-retire counters.
module cheri_id_ex_pipe
    import cheri_id_ex_pipe_pkg::*;
#(
    parameter  int NumPhases = 2,
    localparam int PhaseW    = (NumPhases > 1) ? $clog2(NumPhases) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [PLW-1:0]    in_pl_i,
    output logic              out_valid_o,
    input  logic              ex_ready_i,
    output logic [PLW-1:0]    out_pl_o,
    output logic [PhaseW-1:0] out_phase_o,
    output logic              out_last_o,
    output logic              busy_o
`ifdef CHERI_ID_EX_PERF_EN
    ,
    output logic [15:0]       stall_cnt_o,
    output logic [15:0]       mc_cnt_o
`endif
);

    logic              outValid_q, outValid_d;
    cheri_dec_pl_t     outPl_q, outPl_d;
    logic [PhaseW-1:0] phase_q, phase_d;

    logic           skValid, skReady, skWr, skRd;
    logic [PLW-1:0] skPl;
    logic           inFire, phFire, outLast, retire, loadSlot;

    assign inFire   = in_valid_i & skReady & ~flush_i;
    assign phFire   = outValid_q & ex_ready_i;
    assign outLast  = outValid_q & (~outPl_q.multicycle | (phase_q == PhaseW'(NumPhases - 1)));
    assign retire   = phFire & outLast;
    assign loadSlot = ~outValid_q | retire;

    // The skid only fills while the output slot stays occupied; it drains whenever the slot frees.
    assign skWr = inFire & (~loadSlot | skValid);
    assign skRd = loadSlot & skValid;

    cheri_skid_reg #(.W(PLW)) u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .wr_i    (skWr),
        .data_i  (in_pl_i),
        .rd_i    (skRd),
        .valid_o (skValid),
        .ready_o (skReady),
        .data_o  (skPl)
    );

    always_comb begin
        outValid_d = outValid_q;
        outPl_d    = outPl_q;
        phase_d    = phase_q;
        if (phFire & ~outLast) begin
            phase_d = phase_q + PhaseW'(1);
        end
        if (loadSlot) begin
            phase_d = '0;
            if (skValid) begin
                outValid_d = 1'b1;
                outPl_d    = skPl;
            end else if (inFire) begin
                outValid_d = 1'b1;
                outPl_d    = in_pl_i;
            end else begin
                outValid_d = 1'b0;
            end
        end
    end

    // Flush keeps the stale payload but kills validity; only reset clears the payload.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outValid_q <= 1'b0;
            outPl_q    <= '0;
            phase_q    <= '0;
        end else if (flush_i) begin
            outValid_q <= 1'b0;
            phase_q    <= '0;
        end else begin
            outValid_q <= outValid_d;
            outPl_q    <= outPl_d;
            phase_q    <= phase_d;
        end
    end

    assign in_ready_o  = skReady;
    assign out_valid_o = outValid_q;
    assign out_pl_o    = outPl_q;
    assign out_phase_o = phase_q;
    assign out_last_o  = outLast;
    assign busy_o      = outValid_q | skValid;

`ifdef CHERI_ID_EX_PERF_EN
    logic [15:0] stallCnt_q, mcCnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stallCnt_q <= '0;
            mcCnt_q    <= '0;
        end else begin
            if (outValid_q & ~ex_ready_i & (stallCnt_q != 16'hFFFF)) begin
                stallCnt_q <= stallCnt_q + 16'd1;
            end
            if (retire & outPl_q.multicycle & (mcCnt_q != 16'hFFFF)) begin
                mcCnt_q <= mcCnt_q + 16'd1;
            end
        end
    end

    assign stall_cnt_o = stallCnt_q;
    assign mc_cnt_o    = mcCnt_q;
`endif

endmodule

// File: doc/cheri_id_ex_pipe.md
Name: cheri_id_ex_pipe

Overview:
- Registered handoff between the CHERI instruction decoder (ID) and the CHERI execute unit (EX).
- Captures the decoded operator vector, immediates, cs2 index and control flags behind a valid/ready handshake, with a one-entry skid so that `in_ready_o` is a register output.
- Sequences multicycle operations (two-pass CSetBounds/CRRL/CRAM, non-pipelined tag-safe CLC) by presenting the same entry to EX for NumPhases consecutive handshakes, with phase/last indicators.

Parameters:
- NumPhases, 2, handshakes a multicycle entry occupies in EX; legal 2..4.
- PhaseW, $clog2(NumPhases), width of the phase counter (derived; do not override).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  kill all held entries (branch/exception)
- in_valid_i  in  1  decoder entry valid
- in_ready_o  out  1  pipe can accept an entry
- in_pl_i  in  PLW  packed cheri_dec_pl_t payload: operator[OPDW], imm12, imm20, imm21, cs2[5], rf_we, multicycle
- out_valid_o  out  1  entry presented to EX
- ex_ready_i  in  1  EX accepts current phase
- out_pl_o  out  PLW  presented payload
- out_phase_o  out  PhaseW  current phase index, 0-based
- out_last_o  out  1  current phase is the final one
- busy_o  out  1  any entry held (out or skid)

Behaviour:
- Storage:
  - output register: out_v, out_pl, phase.
  - skid register: sk_v, sk_pl.
- Reset: every valid = 0, phase = 0, payloads = 0, `in_ready_o` = 1, all outputs 0 except `in_ready_o`.
- Definitions:
  - in_fire = in_valid_i & in_ready_o & ~flush_i.
  - ph_fire = out_valid_o & ex_ready_i.
  - retire = ph_fire & out_last_o.
- `in_ready_o` = ~sk_v (registered, no combinational path from `ex_ready_i`).
- `out_last_o` = ~out_pl.multicycle | (phase == NumPhases-1); it is 0 when `out_valid_o` = 0.
- Phase counter:
  - ph_fire & ~out_last_o: phase+1.
  - retire: phase ← 0.
  - payload is held stable across all phases.
- Output load, evaluated when out_v = 0 or retire:
  - sk_v: out ← sk, sk_v ← 0, and additionally in_fire writes the skid.
  - else in_fire: out ← in_pl_i.
  - else out_v ← 0.
- When out_v = 1 and not retiring: in_fire writes the skid (sk_v ← 1).
- Latency: an entry accepted in cycle N is presented in N+1 when the pipe is empty. Single-cycle throughput is 1/cycle with `ex_ready_i` held high. Multicycle entries hold the output for NumPhases handshakes.
- Ordering: strict FIFO; the skid entry is always older than `in_pl_i`.
- Full: out_v & sk_v → `in_ready_o` = 0. On retire in the same cycle, the skid moves to out and `in_ready_o` rises the next cycle.
- flush_i (highest priority, including over rst-free simultaneous retire/in_fire):
  - next cycle: out_v = sk_v = 0, phase = 0.
  - the input offered in the flush cycle is dropped.
  - ph_fire in the flush cycle still counts for EX, but the entry is not retained.
- Flush mid-multicycle: phase is discarded, and the next entry starts at phase 0.
- Reset asserted mid-operation behaves identically to flush, plus payload clear.
- An in_pl_i.multicycle = 1 with a non-multicycle operator is not checked here; the phase sequence still applies.
- `busy_o` = out_v | sk_v.

Optional Feature:
- Macro CHERI_ID_EX_PERF_EN.
- When defined, adds outputs:
  - stall_cnt_o [15:0]: cycles with out_valid_o & ~ex_ready_i.
  - mc_cnt_o [15:0]: retired multicycle entries.
- Both counters saturate at 16'hFFFF, clear on rst_i, and are unaffected by flush_i.
- When undefined, the ports and counter logic are absent and all other behaviour is identical.

Decomposition:
- cheri_pkg additions:
  - typedef cheri_dec_pl_t (packed struct of the fields listed in in_pl_i).
  - localparam PLW = $bits(cheri_dec_pl_t).
  - localparam MAX_PHASES = 4.
- Sub-module cheri_skid_reg: a generic one-entry skid holding register (valid/ready, flush, parameterised width), instantiated once for the skid entry.
- Phase sequencing and output register stay in cheri_id_ex_pipe.

Test Plan:
- Reset then idle: rst_i=1 for 2 cycles → out_valid_o=0, in_ready_o=1, busy_o=0, out_pl_o=0.
- Streaming: 8 single-cycle entries (imm12=0..7), ex_ready_i=1 constantly → each appears 1 cycle after acceptance, in order, one per cycle, in_ready_o never drops.
- Backpressure: ex_ready_i=0 while 3 entries offered → first presented, second in skid, in_ready_o=0, third held upstream. Release ex_ready_i → order 0,1,2, no loss or duplication.
- Multicycle, NumPhases=2: CSET_BOUNDS entry with multicycle=1, ex_ready_i=1 → out_phase_o 0 then 1, out_last_o 0 then 1. The following entry is presented on cycle 3.
- Flush mid-multicycle: assert flush_i at phase 1 with skid full → next cycle out_valid_o=0, busy_o=0. The next accepted entry is presented with out_phase_o=0.
- CHERI_ID_EX_PERF_EN: hold ex_ready_i=0 for 70000 cycles with an entry presented → stall_cnt_o saturates at 16'hFFFF. After one multicycle retire, mc_cnt_o=1.
